divider_seq_param: RTL and testbench

DIVIDER_SEQ_PARAM -- requirements
Module: divider_seq_param

---
 rtl/divider_seq_param.sv | 146 ++++++++++++++
 tb/tb_divider_seq_param.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/divider_seq_param.sv
// Iterative restoring divider (signed/unsigned quotient or remainder) with pass-through tag.
// Latency WIDTH/BITS_PER_CYCLE+2 cycles normal, 2 for divide-by-zero/overflow; result held until out_ready.
module divider_seq_param #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1,
    parameter int TAG_W          = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] num_a,
    input  logic [WIDTH-1:0] den_b,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [TAG_W-1:0] out_tag,
    output logic             div_by_zero,
    output logic             overflow
);
    localparam int ITER  = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(ITER + 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   quot_q, rem_q, div_q;
    logic               sign_q_q, sign_r_q, rem_sel_q, dz_q, ovf_q;
    logic [TAG_W-1:0]   tag_q;
    logic [WIDTH-1:0]   result_q;
    logic [TAG_W-1:0]   out_tag_q;
    logic               dz_out_q, ovf_out_q;

    logic               is_signed, dz_in, ovf_in, special, accept;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH-1:0]   quot_t, rem_t;
    logic [WIDTH:0]     rem_sh, diff;
    logic [WIDTH-1:0]   q_fix, r_fix;

    assign is_signed = ~op[0];
    assign dz_in     = (den_b == '0);
    assign ovf_in    = is_signed && (num_a == MIN_NEG) && (den_b == '1);
    assign special   = dz_in || ovf_in;
    assign accept    = in_valid && (state_q == S_IDLE) && !flush;
    assign a_mag     = (is_signed && num_a[WIDTH-1]) ? -num_a : num_a;
    assign b_mag     = (is_signed && den_b[WIDTH-1]) ? -den_b : den_b;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (in_valid) state_d = special ? S_FIX : S_CALC;
            S_CALC: if (cnt_q == CNT_W'(1)) state_d = S_FIX;
            S_FIX:  state_d = S_DONE;
            S_DONE: if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;
    end

    // Borrow bit of the W+1-bit trial subtraction decides each quotient bit.
    always_comb begin
        rem_t  = rem_q;
        quot_t = quot_q;
        rem_sh = '0;
        diff   = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            rem_sh = {rem_t, quot_t[WIDTH-1]};
            quot_t = {quot_t[WIDTH-2:0], 1'b0};
            diff   = rem_sh - {1'b0, div_q};
            if (!diff[WIDTH]) begin
                rem_t     = diff[WIDTH-1:0];
                quot_t[0] = 1'b1;
            end else begin
                rem_t = rem_sh[WIDTH-1:0];
            end
        end
    end

    assign q_fix = sign_q_q ? -quot_q : quot_q;
    assign r_fix = sign_r_q ? -rem_q  : rem_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            quot_q    <= '0;
            rem_q     <= '0;
            div_q     <= '0;
            sign_q_q  <= 1'b0;
            sign_r_q  <= 1'b0;
            rem_sel_q <= 1'b0;
            dz_q      <= 1'b0;
            ovf_q     <= 1'b0;
            tag_q     <= '0;
            result_q  <= '0;
            out_tag_q <= '0;
            dz_out_q  <= 1'b0;
            ovf_out_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                rem_sel_q <= op[1];
                tag_q     <= in_tag;
                dz_q      <= dz_in;
                ovf_q     <= ovf_in;
                div_q     <= b_mag;
                sign_q_q  <= is_signed && !special && (num_a[WIDTH-1] ^ den_b[WIDTH-1]);
                sign_r_q  <= is_signed && !special && num_a[WIDTH-1];
                // Special cases preload the final answer so FIX handles all paths alike.
                if (dz_in) begin
                    quot_q <= '1;
                    rem_q  <= num_a;
                end else if (ovf_in) begin
                    quot_q <= num_a;
                    rem_q  <= '0;
                end else begin
                    quot_q <= a_mag;
                    rem_q  <= '0;
                    cnt_q  <= CNT_W'(ITER);
                end
            end else if (state_q == S_CALC) begin
                quot_q <= quot_t;
                rem_q  <= rem_t;
                cnt_q  <= cnt_q - CNT_W'(1);
            end
            if (state_q == S_FIX && !flush) begin
                result_q  <= rem_sel_q ? r_fix : q_fix;
                out_tag_q <= tag_q;
                dz_out_q  <= dz_q;
                ovf_out_q <= ovf_q;
            end
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign result      = result_q;
    assign out_tag     = out_tag_q;
    assign div_by_zero = dz_out_q;
    assign overflow    = ovf_out_q;
endmodule

// File: tb/tb_divider_seq_param.sv
// Random and directed checks of divider_seq_param against an arithmetic reference model.
module tb_divider_seq_param;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, in_valid2;
    logic        in_ready, in_ready2;
    logic [1:0]  op;
    logic [31:0] num_a, den_b;
    logic [4:0]  in_tag;
    logic        flush;
    logic        out_valid, out_valid2;
    logic        out_ready;
    logic [31:0] result, result2;
    logic [4:0]  out_tag, out_tag2;
    logic        div_by_zero, div_by_zero2;
    logic        overflow, overflow2;

    int n_chk = 0;
    int n_bad = 0;
    bit sel   = 1'b0;

    always #5 clk = ~clk;

    divider_seq_param #(.WIDTH(32), .BITS_PER_CYCLE(1), .TAG_W(5)) u_dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .num_a(num_a), .den_b(den_b), .in_tag(in_tag), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .out_tag(out_tag), .div_by_zero(div_by_zero), .overflow(overflow)
    );

    divider_seq_param #(.WIDTH(32), .BITS_PER_CYCLE(2), .TAG_W(5)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .op(op), .num_a(num_a), .den_b(den_b), .in_tag(in_tag), .flush(flush),
        .out_valid(out_valid2), .out_ready(out_ready), .result(result2),
        .out_tag(out_tag2), .div_by_zero(div_by_zero2), .overflow(overflow2)
    );

    logic        m_ready, m_valid, m_dz, m_ovf;
    logic [31:0] m_result;
    logic [4:0]  m_tag;
    assign m_ready  = sel ? in_ready2     : in_ready;
    assign m_valid  = sel ? out_valid2    : out_valid;
    assign m_result = sel ? result2       : result;
    assign m_tag    = sel ? out_tag2      : out_tag;
    assign m_dz     = sel ? div_by_zero2  : div_by_zero;
    assign m_ovf    = sel ? overflow2     : overflow;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b, output logic dz, output logic ovf);
        logic [31:0] q, r;
        dz  = 1'b0;
        ovf = 1'b0;
        if (b == 32'd0) begin
            dz = 1'b1; q = 32'hFFFF_FFFF; r = a;
        end else if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            ovf = 1'b1; q = a; r = 32'd0;
        end else if (!o[0]) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return o[1] ? r : q;
    endfunction

    task automatic run(input bit s, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] t, input int hold);
        logic [31:0] er;
        logic edz, eovf;
        int lat, cyc;
        er  = ref_res(o, a, b, edz, eovf);
        lat = (edz || eovf) ? 2 : (s ? 16 : 32) + 2;
        sel = s;
        @(negedge clk);
        check("ready_before", m_ready, 1);
        op = o; num_a = a; den_b = b; in_tag = t;
        out_ready = (hold == 0);
        if (s) in_valid2 = 1'b1; else in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_valid2 = 1'b0;
        cyc = 1;
        while (!m_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("latency", cyc, lat);
        check("result", m_result, er);
        check("div_by_zero", m_dz, edz);
        check("overflow", m_ovf, eovf);
        check("tag", m_tag, t);
        if (hold > 0) begin
            repeat (hold) begin
                @(negedge clk);
                check("bp_valid", m_valid, 1);
                check("bp_result", m_result, er);
                check("bp_tag", m_tag, t);
                check("bp_ready", m_ready, 0);
            end
            out_ready = 1'b1;
        end
        @(negedge clk);
        check("taken_ready", m_ready, 1);
        check("taken_valid", m_valid, 0);
    endtask

    function automatic logic [31:0] pick_operand(input int kind);
        case (kind)
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return $urandom_range(1, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bit seen;
        logic [31:0] a, b;
        reset_n = 1'b0; in_valid = 1'b0; in_valid2 = 1'b0; flush = 1'b0;
        out_ready = 1'b1; op = 2'b00; num_a = '0; den_b = '0; in_tag = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_tag", out_tag, 0);
        check("rst_dz", div_by_zero, 0);
        check("rst_ovf", overflow, 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_ready", in_ready, 1);

        run(0, 2'b00, 32'hFFFF_FFF9, 32'd2, 5'd1, 0);
        run(0, 2'b10, 32'hFFFF_FFF9, 32'd2, 5'd2, 0);
        run(0, 2'b11, 32'd7, 32'd2, 5'd4, 0);
        run(0, 2'b01, 32'd100, 32'd0, 5'd5, 0);
        run(0, 2'b10, 32'h1234, 32'd0, 5'd6, 0);
        run(0, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 0);
        run(0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 0);
        run(0, 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 0);
        run(0, 2'b00, 32'd1000, 32'd33, 5'd3, 5);
        run(0, 2'b00, 32'hFFFF_F000, 32'd77, 5'd7, 0);

        for (int i = 0; i < 40; i++) begin
            a = pick_operand($urandom_range(0, 6));
            b = pick_operand($urandom_range(0, 8));
            run(0, 2'($urandom_range(0, 3)), a, b, 5'($urandom), (i % 8 == 3) ? 2 : 0);
        end

        run(1, 2'b01, 32'd100, 32'd7, 5'd11, 0);
        run(1, 2'b11, 32'd100, 32'd7, 5'd12, 0);
        run(1, 2'b10, 32'd0, 32'd0, 5'd13, 0);
        for (int i = 0; i < 12; i++) begin
            a = pick_operand($urandom_range(0, 6));
            b = pick_operand($urandom_range(0, 8));
            run(1, 2'($urandom_range(0, 3)), a, b, 5'($urandom), 0);
        end
        sel = 1'b0;

        // flush in the middle of an iteration
        @(negedge clk);
        op = 2'b01; num_a = 32'd5000; den_b = 32'd3; in_tag = 5'd20; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_ready", in_ready, 1);
        check("flush_valid", out_valid, 0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("flush_no_result", seen, 0);

        // accept coinciding with flush is dropped
        op = 2'b01; num_a = 32'd9; den_b = 32'd0; in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        check("flush_acc_ready", in_ready, 1);
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("flush_acc_dropped", seen, 0);

        // reset during iteration, after a nonzero result was left on the outputs
        run(0, 2'b01, 32'd91, 32'd0, 5'd21, 0);
        @(negedge clk);
        op = 2'b00; num_a = 32'd12345; den_b = 32'd11; in_tag = 5'd22; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_result", result, 0);
        check("mid_rst_tag", out_tag, 0);
        check("mid_rst_dz", div_by_zero, 0);
        check("mid_rst_ovf", overflow, 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("mid_rst_ready", in_ready, 1);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("mid_rst_no_result", seen, 0);

        run(0, 2'b00, 32'd12345, 32'd11, 5'd23, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
